// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//  - uart_state_e   : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//  - parity_mode_e  : parity selection as latched for one frame
//  - UART_MIN_DIV   : smallest usable clocks-per-bit value
//  - frame-bit constants and parity helper functions
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  localparam int unsigned UART_MIN_DIV   = 2;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_MAX_STOP  = 2;

  // Encode the two parity configuration inputs into one mode value.
  function automatic parity_mode_e parity_mode(input logic en, input logic odd);
    parity_mode_e m;
    if (!en) begin
      m = PAR_NONE;
    end else if (odd) begin
      m = PAR_ODD;
    end else begin
      m = PAR_EVEN;
    end
    return m;
  endfunction

  // Parity bit that makes the total count of ones even (PAR_EVEN) or odd (PAR_ODD).
  function automatic logic parity_bit(input logic [7:0] data, input parity_mode_e mode);
    logic p;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//  Ports: clk, reset (sync, active high), push/din write side, pop/dout read side
//  (dout always shows the head entry while !empty), full, empty, count (entries held).
//  A push while full and a pop while empty are ignored, so the FIFO cannot overflow
//  or underflow. Pointers wrap modulo 2**AW.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_s;
  logic          pop_s;

  // count never exceeds 2**AW, so its top bit alone flags full
  assign full   = count_q[AW];
  assign empty  = (count_q == {(AW+1){1'b0}});
  assign count  = count_q;
  assign dout   = mem_q[rd_ptr_q];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // storage array; contents only become visible through count, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes enter a FIFO over valid/ready and leave on tx_out
// as 8N1/8E1/8O1/8N2 frames, LSB first, baud_div clocks per bit.
//  Inputs : clk, reset (sync, active high), baud_div, parity_en, parity_odd, two_stop,
//           cts_n (async, active low), in_valid, in_data
//  Outputs: in_ready (FIFO not full), tx_out (idle high), tx_busy (frame in progress),
//           tx_done (one-cycle end-of-frame pulse), fifo_count (bytes queued)
// Line outputs are registered from the current FSM state, so the line trails the
// state by one clock: a pop at edge N+1 puts the start bit on tx_out at edge N+2.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic               parity_en,
  input  logic               parity_odd,
  input  logic               two_stop,
  input  logic               cts_n,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               tx_out,
  output logic               tx_busy,
  output logic               tx_done,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam logic [DIV_W-1:0] MIN_DIV_C   = DIV_W'(UART_MIN_DIV);
  localparam logic [DIV_W-1:0] ONE_C       = DIV_W'(1);
  localparam logic [2:0]       LAST_DATA_C = 3'(UART_DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  parity_mode_e     mode_q, mode_d;
  logic             two_stop_q, two_stop_d;
  logic             cts_meta_q, cts_sync_q;
  logic             tx_out_q, tx_busy_q, tx_done_q;

  logic             pop_s, done_s, tx_bit_s, bit_end_s;
  logic             fifo_empty_s, fifo_full_s;
  logic [7:0]       fifo_dout_s;
  logic [DIV_W-1:0] div_clamped_s;

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop_s),
    .din   (in_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  assign in_ready      = !fifo_full_s;
  assign tx_out        = tx_out_q;
  assign tx_busy       = tx_busy_q;
  assign tx_done       = tx_done_q;
  assign div_clamped_s = (baud_div < MIN_DIV_C) ? MIN_DIV_C : baud_div;
  assign bit_end_s     = (cnt_q == (div_q - ONE_C));

  // next-state logic: bit timing, frame sequencing and FIFO pop
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    data_d     = data_q;
    mode_d     = mode_q;
    two_stop_d = two_stop_q;
    pop_s      = 1'b0;
    done_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // frame configuration is captured here and held until the frame ends
        if (!fifo_empty_s && !cts_sync_q) begin
          pop_s      = 1'b1;
          data_d     = fifo_dout_s;
          div_d      = div_clamped_s;
          mode_d     = parity_mode(parity_en, parity_odd);
          two_stop_d = two_stop;
          cnt_d      = {DIV_W{1'b0}};
          bit_d      = 3'd0;
          state_d    = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_d   = {DIV_W{1'b0}};
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d = {DIV_W{1'b0}};
          if (bit_q == LAST_DATA_C) begin
            bit_d   = 3'd0;
            state_d = (mode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          cnt_d   = {DIV_W{1'b0}};
          bit_d   = 3'd0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_d = {DIV_W{1'b0}};
          if (two_stop_q && (bit_q == 3'd0)) begin
            bit_d = 3'd1;
          end else begin
            bit_d   = 3'd0;
            done_s  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // line level for the current state
  always_comb begin
    tx_bit_s = 1'b1;
    case (state_q)
      ST_START:  tx_bit_s = 1'b0;
      ST_DATA:   tx_bit_s = data_q[bit_q];
      ST_PARITY: tx_bit_s = parity_bit(data_q, mode_q);
      default:   tx_bit_s = 1'b1;
    endcase
  end

  // FSM, datapath, CTS synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {DIV_W{1'b0}};
      div_q      <= MIN_DIV_C;
      bit_q      <= 3'd0;
      data_q     <= 8'h00;
      mode_q     <= PAR_NONE;
      two_stop_q <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
      tx_out_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      two_stop_q <= two_stop_d;
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
      tx_out_q   <= tx_bit_s;
      tx_busy_q  <= (state_q != ST_IDLE);
      tx_done_q  <= done_s;
    end
  end

endmodule
